packetmem_sched: RTL and testbench
==================================

PACKETMEM_SCHED -- requirements
Module: packetmem_sched

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the packet-memory address width; the word-length counters are ADDR_WIDTH bits wide.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port snoop_wr_en, input, 1 bit: the snooper is writing one word to the packet memory this cycle.
REQ-005 The block SHALL have port snoop_done, input, 1 bit: the snooper's last word of a packet; valid only together with snoop_wr_en.
REQ-006 The block SHALL have port snoop_mem_ready, output, 1 bit, registered: a buffer is allocated to the snooper.
REQ-007 The block SHALL have port wr_buf_sel, output, 2 bits, registered: index of the buffer the snooper writes into (0..2).
REQ-008 The block SHALL have port rd_ready, output, 1 bit, registered: a full buffer is offered to the filter.
REQ-009 The block SHALL have port rd_buf_sel, output, 2 bits, registered: index of the buffer offered to or held by the filter.
REQ-010 The block SHALL have port rd_len, output, ADDR_WIDTH bits, registered: word count of the buffer at rd_buf_sel.
REQ-011 The block SHALL have port rd_start, input, 1 bit: the filter claims the offered buffer.
REQ-012 The block SHALL have port rd_finish, input, 1 bit: the filter releases the buffer it holds.
REQ-013 The block SHALL have port occupancy, output, 2 bits, registered: number of buffers in state FULL or READING.
REQ-014 The block SHALL have port proto_err, output, 1 bit, registered: sticky protocol-violation flag.

Function
REQ-015 The block SHALL manage three packet buffers, each in one of the states EMPTY, FILLING, FULL or READING, with a word counter and a latched length per buffer.
REQ-016 The block SHALL keep a write pointer and a read pointer, each advancing 0->1->2->0, so the filter receives packets in arrival order.
REQ-017 When no buffer is FILLING and buf[wr_ptr] is EMPTY at a clock edge, that buffer SHALL become FILLING at that edge; snoop_mem_ready=1 and wr_buf_sel=wr_ptr SHALL follow on the next cycle.
REQ-018 Each snoop_wr_en while a buffer is FILLING SHALL increment that buffer's counter, saturating at 2^ADDR_WIDTH-1.
REQ-019 On snoop_wr_en&&snoop_done, the FILLING buffer SHALL become FULL, its length SHALL latch as counter+1 (saturating), its counter SHALL clear, wr_ptr SHALL advance and snoop_mem_ready SHALL be 0 the next cycle; this gives a minimum gap of one cycle before reallocation.
REQ-020 When all three buffers are non-EMPTY, snoop_mem_ready SHALL stay 0 until a buffer at wr_ptr returns to EMPTY.
REQ-021 rd_ready SHALL be 1 exactly when buf[rd_ptr] is FULL and no buffer is READING; rd_buf_sel=rd_ptr and rd_len=the latched length in that case.
REQ-022 rd_start while rd_ready=1 SHALL move the buffer to READING; rd_ready=0 the next cycle, and rd_buf_sel/rd_len SHALL hold.
REQ-023 rd_finish while a buffer is READING SHALL move it to EMPTY and advance rd_ptr; a following FULL buffer SHALL raise rd_ready one cycle later.
REQ-024 A release and a reallocation of the same buffer in one cycle SHALL NOT happen: a buffer released at edge N is claimable by the writer no earlier than edge N+1.
REQ-025 snoop_done and rd_finish in the same cycle SHALL both take effect, and occupancy SHALL remain unchanged.
REQ-026 proto_err SHALL set and stay set until reset on any of the following:
- snoop_wr_en with no buffer FILLING;
- snoop_done without snoop_wr_en;
- rd_start with rd_ready=0;
- rd_finish with no buffer READING.
The offending input SHALL otherwise be ignored.
REQ-027 occupancy SHALL update one cycle after the state change that causes it.

Reset
REQ-028 rst_n=0 SHALL immediately, regardless of clk, set:
- all buffers EMPTY;
- both pointers 0;
- counters and lengths 0;
- snoop_mem_ready, rd_ready, proto_err 0;
- wr_buf_sel, rd_buf_sel, rd_len, occupancy 0.
REQ-029 A reset during a fill or a read SHALL discard that packet; after release, buffer 0 SHALL be allocated on the first edge and snoop_mem_ready=1 on the following cycle.

Verification
REQ-030 Reset release, idle -> snoop_mem_ready=1 with wr_buf_sel=0 by cycle 2; rd_ready=0, occupancy=0.
REQ-031 5 writes, the 5th with done -> rd_ready=1, rd_buf_sel=0, rd_len=5, occupancy=1; snoop_mem_ready low 1 cycle, then high with wr_buf_sel=1.
REQ-032 Three packets of lengths 3/7/2 with no reads -> occupancy=3, snoop_mem_ready=0; after read+finish of buffer 0 -> rd_buf_sel=1, rd_len=7, and buffer 0 reallocated one cycle after release.
REQ-033 snoop_done and rd_finish on the same edge -> both take effect, occupancy unchanged, no proto_err.
REQ-034 rd_start with rd_ready=0, and snoop_wr_en while snoop_mem_ready=0 -> proto_err=1 sticky; buffer states unchanged.
REQ-035 rst_n asserted mid-fill (after 3 writes) -> all outputs 0 immediately; after release, a new packet of 4 reports rd_len=4 in buffer 0.

Source files
------------

// File: rtl/packetmem_sched.sv
// Triple-buffer scheduler between a packet snooper and a filter.
// Buffers rotate in arrival order; outputs are registered from next state.
module packetmem_sched #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  snoop_wr_en,
    input  logic                  snoop_done,
    output logic                  snoop_mem_ready,
    output logic [1:0]            wr_buf_sel,
    output logic                  rd_ready,
    output logic [1:0]            rd_buf_sel,
    output logic [ADDR_WIDTH-1:0] rd_len,
    input  logic                  rd_start,
    input  logic                  rd_finish,
    output logic [1:0]            occupancy,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        READING
    } buf_st_t;

    localparam logic [ADDR_WIDTH-1:0] CMAX = '1;

    buf_st_t               st_q  [3];
    buf_st_t               st_d  [3];
    logic [ADDR_WIDTH-1:0] cnt_q [3];
    logic [ADDR_WIDTH-1:0] cnt_d [3];
    logic [ADDR_WIDTH-1:0] len_q [3];
    logic [ADDR_WIDTH-1:0] len_d [3];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic                  filling, reading, rd_busy_d;
    logic                  err_d;
    logic [1:0]            occ_c;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // The filling buffer is always wr_ptr, the reading one always rd_ptr.
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = proto_err;
        filling  = (st_q[wr_ptr_q] == FILLING);
        reading  = (st_q[rd_ptr_q] == READING);

        if (snoop_wr_en) begin
            if (filling) begin
                if (snoop_done) begin
                    st_d[wr_ptr_q]  = FULL;
                    len_d[wr_ptr_q] = (cnt_q[wr_ptr_q] == CMAX) ?
                                      CMAX : cnt_q[wr_ptr_q] + 1'b1;
                    cnt_d[wr_ptr_q] = '0;
                    wr_ptr_d        = nxt(wr_ptr_q);
                end else begin
                    cnt_d[wr_ptr_q] = (cnt_q[wr_ptr_q] == CMAX) ?
                                      CMAX : cnt_q[wr_ptr_q] + 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end else if (snoop_done) begin
            err_d = 1'b1;
        end

        // Allocation looks at registered state, so a release this edge
        // cannot be reclaimed until the next one.
        if (!filling && st_q[wr_ptr_q] == EMPTY)
            st_d[wr_ptr_q] = FILLING;

        if (rd_start) begin
            if (rd_ready) st_d[rd_ptr_q] = READING;
            else          err_d = 1'b1;
        end

        if (rd_finish) begin
            if (reading) begin
                st_d[rd_ptr_q] = EMPTY;
                rd_ptr_d       = nxt(rd_ptr_q);
            end else begin
                err_d = 1'b1;
            end
        end

        rd_busy_d = 1'b0;
        occ_c     = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (st_d[i] == READING) rd_busy_d = 1'b1;
            if (st_q[i] == FULL || st_q[i] == READING)
                occ_c = occ_c + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                st_q[i]  <= EMPTY;
                cnt_q[i] <= '0;
                len_q[i] <= '0;
            end
            wr_ptr_q        <= 2'd0;
            rd_ptr_q        <= 2'd0;
            snoop_mem_ready <= 1'b0;
            wr_buf_sel      <= 2'd0;
            rd_ready        <= 1'b0;
            rd_buf_sel      <= 2'd0;
            rd_len          <= '0;
            occupancy       <= 2'd0;
            proto_err       <= 1'b0;
        end else begin
            st_q            <= st_d;
            cnt_q           <= cnt_d;
            len_q           <= len_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            snoop_mem_ready <= (st_d[wr_ptr_d] == FILLING);
            wr_buf_sel      <= wr_ptr_d;
            rd_ready        <= (st_d[rd_ptr_d] == FULL) && !rd_busy_d;
            rd_buf_sel      <= rd_ptr_d;
            rd_len          <= len_d[rd_ptr_d];
            occupancy       <= occ_c;
            proto_err       <= err_d;
        end
    end

endmodule

// File: tb/tb_packetmem_sched.sv
// Directed table-driven bench for packetmem_sched.
// Each row is one clock edge (or a reset pulse) with expected outputs.
module tb_packetmem_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       snoop_wr_en = 1'b0;
    logic       snoop_done = 1'b0;
    logic       snoop_mem_ready;
    logic [1:0] wr_buf_sel;
    logic       rd_ready;
    logic [1:0] rd_buf_sel;
    logic [9:0] rd_len;
    logic       rd_start = 1'b0;
    logic       rd_finish = 1'b0;
    logic [1:0] occupancy;
    logic       proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    packetmem_sched #(.ADDR_WIDTH(10)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .snoop_wr_en     (snoop_wr_en),
        .snoop_done      (snoop_done),
        .snoop_mem_ready (snoop_mem_ready),
        .wr_buf_sel      (wr_buf_sel),
        .rd_ready        (rd_ready),
        .rd_buf_sel      (rd_buf_sel),
        .rd_len          (rd_len),
        .rd_start        (rd_start),
        .rd_finish       (rd_finish),
        .occupancy       (occupancy),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       r;
        bit       we, dn, st, fn;
        bit       mr;
        bit [1:0] ws;
        bit       rr;
        bit [1:0] rs;
        bit [9:0] len;
        bit [1:0] occ;
        bit       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(bit r, bit we, bit dn, bit st, bit fn,
                               bit mr, int ws, bit rr, int rs,
                               int len, int occ, bit err);
        vec_t v;
        v.r = r; v.we = we; v.dn = dn; v.st = st; v.fn = fn;
        v.mr = mr; v.ws = 2'(ws); v.rr = rr; v.rs = 2'(rs);
        v.len = 10'(len); v.occ = 2'(occ); v.err = err;
        return v;
    endfunction

    function automatic vec_t RST();
        return V(0, 0,0,0,0, 0,0,0,0,0,0,0);
    endfunction

    task automatic check(input string tag, input vec_t v);
        logic [18:0] got, exp;
        got = {snoop_mem_ready, wr_buf_sel, rd_ready, rd_buf_sel,
               rd_len, occupancy, proto_err};
        exp = {v.mr, v.ws, v.rr, v.rs, v.len, v.occ, v.err};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got mr=%b ws=%0d rr=%b rs=%0d len=%0d occ=%0d err=%b, want mr=%b ws=%0d rr=%b rs=%0d len=%0d occ=%0d err=%b",
                     tag, got[18], got[17:16], got[15], got[14:13],
                     got[12:3], got[2:1], got[0], v.mr, v.ws, v.rr,
                     v.rs, v.len, v.occ, v.err);
        end
    endtask

    // Called right after a check (#1 past an edge) or at time 0.
    task automatic step(input string tag, input vec_t v);
        snoop_wr_en = v.we;
        snoop_done  = v.dn;
        rd_start    = v.st;
        rd_finish   = v.fn;
        if (!v.r) begin
            rst_n = 1'b0;
            #2;
            check(tag, v);
            rst_n = 1'b1;
        end else begin
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            check(tag, v);
        end
    endtask

    initial begin
        // single packet of 5
        tbl.push_back(RST());
        tbl.push_back(V(1, 0,0,0,0, 1,0,0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(V(1, 1,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(V(1, 1,1,0,0, 0,1,1,0,5,0,0));
        tbl.push_back(V(1, 0,0,0,0, 1,1,1,0,5,1,0));
        // packets 3/7/2, then read buffer 0, then done+finish together
        tbl.push_back(RST());
        tbl.push_back(V(1, 0,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(V(1, 1,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(V(1, 1,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(V(1, 1,1,0,0, 0,1,1,0,3,0,0));
        tbl.push_back(V(1, 0,0,0,0, 1,1,1,0,3,1,0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(V(1, 1,0,0,0, 1,1,1,0,3,1,0));
        tbl.push_back(V(1, 1,1,0,0, 0,2,1,0,3,1,0));
        tbl.push_back(V(1, 0,0,0,0, 1,2,1,0,3,2,0));
        tbl.push_back(V(1, 1,0,0,0, 1,2,1,0,3,2,0));
        tbl.push_back(V(1, 1,1,0,0, 0,0,1,0,3,2,0));
        tbl.push_back(V(1, 0,0,0,0, 0,0,1,0,3,3,0));
        tbl.push_back(V(1, 0,0,1,0, 0,0,0,0,3,3,0));
        tbl.push_back(V(1, 0,0,0,1, 0,0,1,1,7,3,0));
        tbl.push_back(V(1, 0,0,0,0, 1,0,1,1,7,2,0));
        tbl.push_back(V(1, 0,0,1,0, 1,0,0,1,7,2,0));
        tbl.push_back(V(1, 1,0,0,0, 1,0,0,1,7,2,0));
        tbl.push_back(V(1, 1,1,0,1, 0,1,1,2,2,2,0));
        tbl.push_back(V(1, 0,0,0,0, 1,1,1,2,2,2,0));
        // protocol errors are sticky and the bad input is ignored
        tbl.push_back(RST());
        tbl.push_back(V(1, 0,0,0,0, 1,0,0,0,0,0,0));
        tbl.push_back(V(1, 0,0,1,0, 1,0,0,0,0,0,1));
        tbl.push_back(V(1, 1,1,0,0, 0,1,1,0,1,0,1));
        tbl.push_back(V(1, 1,0,0,0, 1,1,1,0,1,1,1));
        tbl.push_back(V(1, 1,0,0,0, 1,1,1,0,1,1,1));
        tbl.push_back(V(1, 1,1,0,0, 0,2,1,0,1,1,1));
        tbl.push_back(V(1, 0,0,1,0, 1,2,0,0,1,2,1));
        tbl.push_back(V(1, 0,0,0,1, 1,2,1,1,2,2,1));
        tbl.push_back(RST());
        tbl.push_back(V(1, 0,0,0,1, 1,0,0,0,0,0,1));
        tbl.push_back(RST());
        tbl.push_back(V(1, 0,1,0,0, 1,0,0,0,0,0,1));
        tbl.push_back(RST());
        tbl.push_back(V(1, 1,0,0,0, 1,0,0,0,0,0,1));

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("row%0d", i), tbl[i]);

        // mid-fill async reset: first build up non-zero outputs
        step("ar_a", V(1, 0,0,0,0, 1,0,0,0,0,0,1));
        step("ar_b", V(1, 1,0,0,0, 1,0,0,0,0,0,1));
        step("ar_c", V(1, 1,1,0,0, 0,1,1,0,2,0,1));
        step("ar_d", V(1, 0,0,0,0, 1,1,1,0,2,1,1));
        for (int i = 0; i < 3; i++)
            step("ar_w", V(1, 1,0,0,0, 1,1,1,0,2,1,1));
        snoop_wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", RST());
        #1;
        rst_n = 1'b1;
        step("ar_alloc", V(1, 0,0,0,0, 1,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++)
            step("ar_w4", V(1, 1,0,0,0, 1,0,0,0,0,0,0));
        step("ar_len4", V(1, 1,1,0,0, 0,1,1,0,4,0,0));

        // counter saturation on a 1101-word packet in buffer 1
        step("sat_alloc", V(1, 0,0,0,0, 1,1,1,0,4,1,0));
        for (int i = 0; i < 1100; i++)
            step("sat_w", V(1, 1,0,0,0, 1,1,1,0,4,1,0));
        step("sat_done", V(1, 1,1,0,0, 0,2,1,0,4,1,0));
        step("sat_start", V(1, 0,0,1,0, 1,2,0,0,4,2,0));
        step("sat_len", V(1, 0,0,0,1, 1,2,1,1,1023,2,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
